doraemon_tally: RTL and testbench
=================================

DORAEMON_TALLY -- requirements
Module: doraemon_tally

Interface
REQ-001 Parameter: TOTAL, default 5996, number of results accepted per tally round (1..8191).
REQ-002 clk2  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  result-strobe from the CDC stage output (out_valid), one result per high cycle.
REQ-005 in_data  input  8  result byte: [7:5] winning slot index, [4:0] doraemon_id.
REQ-006 rpt_ready  input  1  consumer accepts the report.
REQ-007 rpt_valid  output  1  report available, held until accepted.
REQ-008 rpt_id  output  5  doraemon_id with the highest win count this round.
REQ-009 rpt_count  output  13  win count of rpt_id.
REQ-010 busy  output  1  high whenever state is not COLLECT.
REQ-011 drop_err  output  1  sticky: a result arrived while busy.
REQ-012 slot_err  output  1  sticky: a result carried slot index > 4 (see Configuration).

Function
REQ-013 States: COLLECT, SCAN, REPORT, CLEAR; encoded in 2 bits.
REQ-014 COLLECT: each cycle with in_valid=1, bin[in_data[4:0]] increments and rx_cnt increments at the same edge.
REQ-015 Bins are 32 x 13-bit counters; a bin at 8191 saturates (no wrap).
REQ-016 When the accepted result is the TOTAL-th of the round, next state is SCAN.
REQ-017 SCAN: 32 cycles, one bin per cycle, index 0 to 31; candidate replaced only on strictly greater count, so ties resolve to lowest id; all-zero bins report id 0, count 0.
REQ-018 After index 31, next state is REPORT; rpt_valid rises at edge 33 after the edge accepting the TOTAL-th result.
REQ-019 REPORT: rpt_valid=1, rpt_id/rpt_count stable; rpt_valid&&rpt_ready at an edge -> CLEAR.
REQ-020 CLEAR: single cycle; all bins, rx_cnt and candidate zeroed; rpt_valid low; next state COLLECT.
REQ-021 in_valid while busy: result discarded, no bin/rx_cnt change, drop_err set at that edge.
REQ-022 rpt_id/rpt_count are 0 whenever rpt_valid=0.
REQ-023 busy is registered-state decode: 0 in COLLECT, 1 in SCAN/REPORT/CLEAR.
REQ-024 drop_err and slot_err clear only on reset.

Reset
REQ-025 rst_n low asynchronously forces: state COLLECT, all bins 0, rx_cnt 0, rpt_valid 0, rpt_id 0, rpt_count 0, drop_err 0, slot_err 0.
REQ-026 Reset mid-SCAN or mid-REPORT abandons the round; no report is emitted afterwards.
REQ-027 First in_valid after rst_n deassertion is accepted normally.

Configuration
REQ-028 Macro TALLY_SLOT_CHECK_EN: when defined, an accepted result with in_data[7:5] > 4 sets slot_err (result still counted by id); when undefined, slot_err is constant 0 and in_data[7:5] is ignored.

Verification
REQ-029 TOTAL=4; ids 3,3,7,3 on consecutive cycles -> rpt_valid 33 cycles after 4th, rpt_id=3, rpt_count=3.
REQ-030 TOTAL=4; ids 9,2,9,2 -> tie, rpt_id=2, rpt_count=2.
REQ-031 TOTAL=2; ids 5,5, then in_valid id 1 during SCAN -> drop_err=1, report id 5 count 2; after rpt_ready, next round bins start from 0.
REQ-032 rpt_ready held low 100 cycles in REPORT -> rpt_valid/rpt_id/rpt_count stable throughout; busy=1.
REQ-033 With TALLY_SLOT_CHECK_EN: in_data=8'hE1 -> slot_err=1, bin 1 incremented; without macro slot_err stays 0.
REQ-034 Assert rst_n low during SCAN cycle 10 -> all outputs 0 immediately, no rpt_valid thereafter without new TOTAL results.

Source files
------------

// File: rtl/doraemon_tally.sv
// doraemon_tally
// Counts per-id wins over a round of TOTAL results. It then scans the 32 bins
// for the id with the most wins and offers it as a report. When the report is
// taken, all counters are cleared for the next round.
//
// Parameter:
//   TOTAL        results accepted per round (1..8191)
// Optional feature:
//   TALLY_SLOT_CHECK_EN  when defined, an accepted result whose slot index
//                        in_data[7:5] is above 4 sets slot_err. When it is not
//                        defined, slot_err is tied to 0.
// Ports:
//   clk2         clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     result strobe, one result per high cycle
//   in_data      [7:5] slot index, [4:0] doraemon_id
//   rpt_ready    consumer accepts the report
//   rpt_valid    report available; held until accepted
//   rpt_id       winning id (0 while rpt_valid is low)
//   rpt_count    win count of rpt_id (0 while rpt_valid is low)
//   busy         high whenever the FSM is not in COLLECT
//   drop_err     sticky: a result arrived while busy
//   slot_err     sticky: a result carried a slot index above 4
//   dbg_state_o  current FSM state (0 COLLECT, 1 SCAN, 2 REPORT, 3 CLEAR)
//
// Handshake: a report transfers on a rising edge where rpt_valid && rpt_ready.
// rpt_valid never depends on rpt_ready, and the report fields stay stable
// until that transfer happens.
module doraemon_tally #(
    parameter int TOTAL = 5996
) (
    input  logic        clk2,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        rpt_ready,
    output logic        rpt_valid,
    output logic [4:0]  rpt_id,
    output logic [12:0] rpt_count,
    output logic        busy,
    output logic        drop_err,
    output logic        slot_err,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCAN    = 2'd1,
        REPORT  = 2'd2,
        CLEAR   = 2'd3
    } state_e;

    localparam logic [12:0] LAST    = 13'(TOTAL - 1);
    localparam logic [12:0] BIN_MAX = 13'h1FFF;

    state_e      state_q, state_d;
    logic [12:0] bins_q [32];
    logic [12:0] bins_d [32];
    logic [12:0] rx_cnt_q, rx_cnt_d;
    // Bit 5 marks the extra settle cycle after bin 31 has been compared.
    logic [5:0]  scan_idx_q, scan_idx_d;
    logic [4:0]  cand_id_q, cand_id_d;
    logic [12:0] cand_cnt_q, cand_cnt_d;
    logic        drop_err_q, drop_err_d;
    logic        slot_err_q, slot_err_d;

    logic        accept;
    logic [4:0]  bin_sel;
    logic [12:0] scan_bin;

    assign accept   = in_valid && (state_q == COLLECT);
    assign bin_sel  = in_data[4:0];
    assign scan_bin = bins_q[scan_idx_q[4:0]];

`ifndef TALLY_SLOT_CHECK_EN
    logic unused_slot;
    assign unused_slot = ^in_data[7:5];
`endif

    always_comb begin
        state_d    = state_q;
        bins_d     = bins_q;
        rx_cnt_d   = rx_cnt_q;
        scan_idx_d = scan_idx_q;
        cand_id_d  = cand_id_q;
        cand_cnt_d = cand_cnt_q;
        drop_err_d = drop_err_q;
        slot_err_d = slot_err_q;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (bins_q[bin_sel] != BIN_MAX) begin
                        bins_d[bin_sel] = bins_q[bin_sel] + 13'd1;
                    end
                    rx_cnt_d = rx_cnt_q + 13'd1;
                    if (rx_cnt_q == LAST) begin
                        state_d    = SCAN;
                        scan_idx_d = 6'd0;
                    end
                end
            end
            SCAN: begin
                // Indices 0..31 compare one bin each. Index 32 is a settle
                // cycle, so the report rises 33 edges after the last result.
                if (scan_idx_q[5]) begin
                    state_d = REPORT;
                end else begin
                    // Strictly greater: ties keep the lower id found earlier.
                    if (scan_bin > cand_cnt_q) begin
                        cand_id_d  = scan_idx_q[4:0];
                        cand_cnt_d = scan_bin;
                    end
                    scan_idx_d = scan_idx_q + 6'd1;
                end
            end
            REPORT: begin
                if (rpt_ready) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                for (int i = 0; i < 32; i++) begin
                    bins_d[i] = 13'd0;
                end
                rx_cnt_d   = 13'd0;
                scan_idx_d = 6'd0;
                cand_id_d  = 5'd0;
                cand_cnt_d = 13'd0;
                state_d    = COLLECT;
            end
            default: state_d = COLLECT;
        endcase

        if (in_valid && (state_q != COLLECT)) begin
            drop_err_d = 1'b1;
        end

`ifdef TALLY_SLOT_CHECK_EN
        if (accept && (in_data[7:5] > 3'd4)) begin
            slot_err_d = 1'b1;
        end
`else
        slot_err_d = 1'b0;
`endif
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            for (int i = 0; i < 32; i++) begin
                bins_q[i] <= 13'd0;
            end
            rx_cnt_q   <= 13'd0;
            scan_idx_q <= 6'd0;
            cand_id_q  <= 5'd0;
            cand_cnt_q <= 13'd0;
            drop_err_q <= 1'b0;
            slot_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bins_q     <= bins_d;
            rx_cnt_q   <= rx_cnt_d;
            scan_idx_q <= scan_idx_d;
            cand_id_q  <= cand_id_d;
            cand_cnt_q <= cand_cnt_d;
            drop_err_q <= drop_err_d;
            slot_err_q <= slot_err_d;
        end
    end

    assign rpt_valid   = (state_q == REPORT);
    assign rpt_id      = rpt_valid ? cand_id_q  : 5'd0;
    assign rpt_count   = rpt_valid ? cand_cnt_q : 13'd0;
    assign busy        = (state_q != COLLECT);
    assign drop_err    = drop_err_q;
    assign slot_err    = slot_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_doraemon_tally.sv
module tb_doraemon_tally;

    // ---------------- clock / reset ----------------
    logic clk2 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk2 = ~clk2;

    // TOTAL=4 instance
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        rpt_ready = 1'b0;
    logic        rpt_valid;
    logic [4:0]  rpt_id;
    logic [12:0] rpt_count;
    logic        busy, drop_err, slot_err;
    logic [1:0]  dbg_state;

    // TOTAL=2 instance
    logic        in_valid2 = 1'b0;
    logic [7:0]  in_data2 = 8'd0;
    logic        rpt_ready2 = 1'b0;
    logic        rpt_valid2;
    logic [4:0]  rpt_id2;
    logic [12:0] rpt_count2;
    logic        busy2, drop_err2, slot_err2;
    logic [1:0]  dbg_state2;

    doraemon_tally #(.TOTAL(4)) u_dut4 (
        .clk2(clk2), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .rpt_ready(rpt_ready), .rpt_valid(rpt_valid), .rpt_id(rpt_id),
        .rpt_count(rpt_count), .busy(busy), .drop_err(drop_err),
        .slot_err(slot_err), .dbg_state_o(dbg_state)
    );

    doraemon_tally #(.TOTAL(2)) u_dut2 (
        .clk2(clk2), .rst_n(rst_n), .in_valid(in_valid2), .in_data(in_data2),
        .rpt_ready(rpt_ready2), .rpt_valid(rpt_valid2), .rpt_id(rpt_id2),
        .rpt_count(rpt_count2), .busy(busy2), .drop_err(drop_err2),
        .slot_err(slot_err2), .dbg_state_o(dbg_state2)
    );

    // ---------------- scoreboard ----------------
    logic [17:0] exp_q[$];   // {id[4:0], count[12:0]}
    int n_vec = 0;
    int n_err = 0;

`ifdef TALLY_SLOT_CHECK_EN
    localparam int SLOT_EXP = 1;
`else
    localparam int SLOT_EXP = 0;
`endif

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Independent reference: count wins per id, pick the highest, lowest id on ties.
    function automatic logic [17:0] model(input logic [31:0] d);
        int cnt[32];
        int best_id;
        int best_cnt;
        for (int k = 0; k < 32; k++) cnt[k] = 0;
        for (int i = 0; i < 4; i++) cnt[d[8*i +: 5]]++;
        best_id = 0;
        best_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            if (cnt[k] > best_cnt) begin
                best_cnt = cnt[k];
                best_id = k;
            end
        end
        return {5'(best_id), 13'(best_cnt)};
    endfunction

    // ---------------- driver: one TOTAL=4 round ----------------
    task automatic run_round(input logic [31:0] data, input logic [17:0] exp, input int stall);
        int n;
        logic [17:0] e;
        exp_q.push_back(exp);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = data[8*i +: 8];
            @(posedge clk2); #1;
        end
        in_valid = 1'b0;
        check("busy_in_scan", int'(busy), 1);
        n = 0;
        while (!rpt_valid && n < 40) begin
            @(posedge clk2); #1;
            n++;
        end
        check("report_latency", n, 33);
        e = exp_q.pop_front();
        if (rpt_valid) begin
            check("rpt_id", int'(rpt_id), int'(e[17:13]));
            check("rpt_count", int'(rpt_count), int'(e[12:0]));
            check("busy_in_report", int'(busy), 1);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk2); #1;
                check("stall_hold", int'({rpt_valid, rpt_id, rpt_count, busy}),
                      int'({1'b1, e, 1'b1}));
            end
            rpt_ready = 1'b1;
            @(posedge clk2); #1;
            rpt_ready = 1'b0;
            check("clear_outputs", int'({rpt_valid, rpt_id, rpt_count, busy}), 1);
            @(posedge clk2); #1;
            check("back_to_collect", int'(busy), 0);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [4:0]  exp_id;
        logic [12:0] exp_cnt;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int viol;
        logic [31:0] rd;

        // Byte 0 is sent first.
        vecs[0] = '{32'h03_07_03_03, 5'd3,  13'd3};  // 3,3,7,3
        vecs[1] = '{32'h02_09_02_09, 5'd2,  13'd2};  // 9,2,9,2 tie
        vecs[2] = '{32'h00_00_00_00, 5'd0,  13'd4};  // all id 0
        vecs[3] = '{32'h1E_1F_1E_1F, 5'd30, 13'd2};  // 31,30 tie at top ids

        // Reset state
        repeat (3) @(posedge clk2);
        #1;
        check("reset_outputs", int'({rpt_valid, rpt_id, rpt_count, busy, drop_err, slot_err}), 0);
        check("reset_state", int'(dbg_state), 0);
        @(negedge clk2);
        rst_n = 1'b1;
        @(posedge clk2); #1;

        // Table vectors, first one with a 100-cycle report stall
        for (int v = 0; v < 4; v++) begin
            run_round(vecs[v].data, {vecs[v].exp_id, vecs[v].exp_cnt}, (v == 0) ? 100 : 0);
        end
        check("no_drop", int'(drop_err), 0);
        check("slot_err_clean", int'(slot_err), 0);

        // Random rounds with ids in a small range so repeats and ties happen
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) begin
                rd[8*i +: 8] = {3'($urandom_range(0, 4)), 5'($urandom_range(0, 7))};
            end
            run_round(rd, model(rd), 0);
        end

        // Slot index 7 on id 1 (8'hE1). Each id wins once, so id 1 is the answer.
        run_round(32'h10_08_04_E1, {5'd1, 13'd1}, 0);
        check("slot_err", int'(slot_err), SLOT_EXP);

        // TOTAL=2: 5,5, then a result during SCAN is dropped
        for (int i = 0; i < 2; i++) begin
            in_valid2 = 1'b1;
            in_data2 = 8'h05;
            @(posedge clk2); #1;
        end
        in_data2 = 8'h01;
        @(posedge clk2); #1;
        in_valid2 = 1'b0;
        check("drop_err", int'(drop_err2), 1);
        viol = 0;
        while (!rpt_valid2 && viol < 40) begin
            @(posedge clk2); #1;
            viol++;
        end
        check("drop_rpt_valid", int'(rpt_valid2), 1);
        check("drop_rpt_id", int'(rpt_id2), 5);
        check("drop_rpt_count", int'(rpt_count2), 2);
        rpt_ready2 = 1'b1;
        @(posedge clk2); #1;
        rpt_ready2 = 1'b0;
        @(posedge clk2); #1;
        // Next round 9,9: stale bin 5 would tie at 2 and win on the lower id.
        for (int i = 0; i < 2; i++) begin
            in_valid2 = 1'b1;
            in_data2 = 8'h09;
            @(posedge clk2); #1;
        end
        in_valid2 = 1'b0;
        viol = 0;
        while (!rpt_valid2 && viol < 40) begin
            @(posedge clk2); #1;
            viol++;
        end
        check("round2_rpt_id", int'(rpt_id2), 9);
        check("round2_rpt_count", int'(rpt_count2), 2);
        check("drop_err_sticky", int'(drop_err2), 1);
        rpt_ready2 = 1'b1;
        @(posedge clk2); #1;
        rpt_ready2 = 1'b0;

        // Reset during SCAN cycle 10
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 8'h03;
            @(posedge clk2); #1;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk2);
        #3;
        rst_n = 1'b0;
        #1;
        check("midscan_reset_outputs",
              int'({rpt_valid, rpt_id, rpt_count, busy, drop_err, slot_err}), 0);
        check("midscan_reset_dut2_drop", int'(drop_err2), 0);
        @(negedge clk2);
        rst_n = 1'b1;
        viol = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk2); #1;
            if (rpt_valid || busy) viol++;
        end
        check("no_report_after_reset", viol, 0);
        // First round after reset starts from empty bins.
        run_round(vecs[0].data, {vecs[0].exp_id, vecs[0].exp_cnt}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
